// File: rtl/alsu_pkg.sv
// Shared constants, state encoding and select codes for the ALSU issue sequencer.
// Imported by the interface, the register file and the sequencer top.
package alsu_pkg;

    localparam int DATA_W = 4;
    localparam int RES_W  = 8;
    localparam int SEL_W  = 5;
    localparam int NREGS  = 4;
    localparam int AW     = $clog2(NREGS);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_RESP
    } state_t;

    localparam logic [SEL_W-1:0] SEL_PASS = 5'b00000;
    localparam logic [SEL_W-1:0] SEL_ADD  = 5'b00010;
    localparam logic [SEL_W-1:0] SEL_SUB  = 5'b00101;

endpackage

// File: rtl/alsu_issue_seq_if.sv
// Bundle of command, load, ALSU-drive and response signals of the sequencer.
// master = front-end/test side, slave = sequencer side.
interface alsu_issue_seq_if;
    import alsu_pkg::*;

    logic              cmd_valid;
    logic              cmd_ready;
    logic [SEL_W-1:0]  cmd_op;
    logic [AW-1:0]     cmd_rs1;
    logic [AW-1:0]     cmd_rs2;
    logic [AW-1:0]     cmd_rd;
    logic              cmd_wb;

    logic              ld_en;
    logic [AW-1:0]     ld_addr;
    logic [DATA_W-1:0] ld_data;

    logic [SEL_W-1:0]  alsu_select;
    logic [DATA_W-1:0] alsu_a;
    logic [DATA_W-1:0] alsu_b;
    logic [RES_W-1:0]  alsu_result;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [RES_W-1:0]  rsp_data;
    logic              rsp_zero;
    logic              rsp_carry;

    modport master (
        output cmd_valid, cmd_op, cmd_rs1, cmd_rs2, cmd_rd, cmd_wb,
        output ld_en, ld_addr, ld_data,
        output alsu_result, rsp_ready,
        input  cmd_ready, alsu_select, alsu_a, alsu_b,
        input  rsp_valid, rsp_data, rsp_zero, rsp_carry
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_rs1, cmd_rs2, cmd_rd, cmd_wb,
        input  ld_en, ld_addr, ld_data,
        input  alsu_result, rsp_ready,
        output cmd_ready, alsu_select, alsu_a, alsu_b,
        output rsp_valid, rsp_data, rsp_zero, rsp_carry
    );

endinterface

// File: rtl/alsu_regfile.sv
// NREGS x DATA_W register file: two async read ports, load and writeback writes.
// Ports: ra1/ra2 -> rd1/rd2 reads; ld_* direct load; wb_* result writeback (wins on same address).
module alsu_regfile
    import alsu_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [AW-1:0]     ra1,
    input  logic [AW-1:0]     ra2,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2,
    input  logic              ld_en,
    input  logic [AW-1:0]     ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              wb_en,
    input  logic [AW-1:0]     wb_addr,
    input  logic [DATA_W-1:0] wb_data
);

    logic [DATA_W-1:0] rf [NREGS];
    logic              ld_hit;

    // A load colliding with a writeback to the same entry is dropped.
    assign ld_hit = ld_en && !(wb_en && (wb_addr == ld_addr));

    assign rd1 = rf[ra1];
    assign rd2 = rf[ra2];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                rf[i] <= '0;
            end
        end else begin
            if (ld_hit) begin
                rf[ld_addr] <= ld_data;
            end
            if (wb_en) begin
                rf[wb_addr] <= wb_data;
            end
        end
    end

endmodule

// File: rtl/alsu_issue_seq.sv
// Sequencer in front of the 4-bit ALSU: one command in flight, IDLE -> ISSUE -> RESP.
// Ports: clk, rst_n (async active-low), bus (slave side of alsu_issue_seq_if).
module alsu_issue_seq
    import alsu_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    alsu_issue_seq_if.slave  bus
);

    state_t            state;
    state_t            state_nx;
    logic              accept;
    logic              capture;

    logic [SEL_W-1:0]  sel_q;
    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] b_q;
    logic [AW-1:0]     rd_q;
    logic              wb_q;
    logic [RES_W-1:0]  rsp_q;

    logic [DATA_W-1:0] rf_rd1;
    logic [DATA_W-1:0] rf_rd2;
    logic              wb_en;

    assign wb_en = capture && wb_q;

    alsu_regfile u_rf (
        .clk     (clk),
        .rst_n   (rst_n),
        .ra1     (bus.cmd_rs1),
        .ra2     (bus.cmd_rs2),
        .rd1     (rf_rd1),
        .rd2     (rf_rd2),
        .ld_en   (bus.ld_en),
        .ld_addr (bus.ld_addr),
        .ld_data (bus.ld_data),
        .wb_en   (wb_en),
        .wb_addr (rd_q),
        .wb_data (bus.alsu_result[DATA_W-1:0])
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        capture  = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (bus.cmd_valid) begin
                    accept   = 1'b1;
                    state_nx = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                capture  = 1'b1;
                state_nx = ST_RESP;
            end
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    state_nx = ST_IDLE;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // Operands are sampled from the pre-edge register contents.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_q <= '0;
            a_q   <= '0;
            b_q   <= '0;
            rd_q  <= '0;
            wb_q  <= 1'b0;
        end else if (accept) begin
            sel_q <= bus.cmd_op;
            a_q   <= rf_rd1;
            b_q   <= rf_rd2;
            rd_q  <= bus.cmd_rd;
            wb_q  <= bus.cmd_wb;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_q <= '0;
        end else if (capture) begin
            rsp_q <= bus.alsu_result;
        end
    end

    assign bus.cmd_ready   = (state == ST_IDLE);
    assign bus.rsp_valid   = (state == ST_RESP);
    assign bus.alsu_select = sel_q;
    assign bus.alsu_a      = a_q;
    assign bus.alsu_b      = b_q;
    assign bus.rsp_data    = rsp_q;
    assign bus.rsp_zero    = (rsp_q == '0);
    assign bus.rsp_carry   = rsp_q[DATA_W];

endmodule

// File: tb/tb_alsu_issue_seq.sv
// Directed plus random bench for alsu_issue_seq with a behavioural ALSU and register-file model.
// Drives at the falling edge, checks at the falling edge.
module tb_alsu_issue_seq;
    import alsu_pkg::*;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    logic [3:0] m_rf [4];

    alsu_issue_seq_if bus ();

    alsu_issue_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] alsu_fn(input logic [4:0] op,
                                           input logic [3:0] a,
                                           input logic [3:0] b);
        int r;
        case (op)
            5'b00000: r = a;
            5'b00010: r = a + b;
            5'b00101: r = (a - b) & 8'hFF;
            default:  r = ((op[3:0] ^ b) << 4) | a;
        endcase
        return 8'(r);
    endfunction

    always_comb bus.alsu_result = alsu_fn(bus.alsu_select, bus.alsu_a, bus.alsu_b);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic ld(input logic [1:0] addr, input logic [3:0] data);
        bus.ld_en   = 1'b1;
        bus.ld_addr = addr;
        bus.ld_data = data;
        @(posedge clk);
        m_rf[addr] = data;
        @(negedge clk);
        bus.ld_en = 1'b0;
    endtask

    // Full command: optional load on the accept edge (la_*) and on the ISSUE edge (li_*),
    // then `stall` cycles of response backpressure.
    task automatic run_cmd(input logic [4:0] op, input logic [1:0] rs1, input logic [1:0] rs2,
                           input logic [1:0] rd, input logic wb,
                           input logic la_en, input logic [1:0] la_addr, input logic [3:0] la_data,
                           input logic li_en, input logic [1:0] li_addr, input logic [3:0] li_data,
                           input int stall);
        logic [3:0] ea;
        logic [3:0] eb;
        logic [7:0] er;
        ea = m_rf[rs1];
        eb = m_rf[rs2];
        er = alsu_fn(op, ea, eb);
        chk("cmd_ready_idle", bus.cmd_ready, 1);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_rs1   = rs1;
        bus.cmd_rs2   = rs2;
        bus.cmd_rd    = rd;
        bus.cmd_wb    = wb;
        bus.ld_en     = la_en;
        bus.ld_addr   = la_addr;
        bus.ld_data   = la_data;
        @(posedge clk);
        if (la_en) m_rf[la_addr] = la_data;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        bus.ld_en     = li_en;
        bus.ld_addr   = li_addr;
        bus.ld_data   = li_data;
        chk("issue_rsp_valid", bus.rsp_valid, 0);
        chk("issue_cmd_ready", bus.cmd_ready, 0);
        chk("issue_select", bus.alsu_select, op);
        chk("issue_a", bus.alsu_a, ea);
        chk("issue_b", bus.alsu_b, eb);
        @(posedge clk);
        if (li_en) m_rf[li_addr] = li_data;
        if (wb) m_rf[rd] = er[3:0];
        @(negedge clk);
        bus.ld_en = 1'b0;
        for (int s = 0; s < stall; s++) begin
            chk("stall_rsp_valid", bus.rsp_valid, 1);
            chk("stall_rsp_data", bus.rsp_data, er);
            chk("stall_a", bus.alsu_a, ea);
            chk("stall_select", bus.alsu_select, op);
            chk("stall_cmd_ready", bus.cmd_ready, 0);
            bus.cmd_valid = 1'b1;
            bus.cmd_op    = ~op;
            bus.cmd_rs1   = ~rs1;
            @(negedge clk);
        end
        bus.cmd_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        chk("rsp_valid", bus.rsp_valid, 1);
        chk("rsp_data", bus.rsp_data, er);
        chk("rsp_zero", bus.rsp_zero, (er == 8'h00));
        chk("rsp_carry", bus.rsp_carry, er[4]);
        @(posedge clk);
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        chk("done_rsp_valid", bus.rsp_valid, 0);
        chk("done_cmd_ready", bus.cmd_ready, 1);
        chk("done_select_held", bus.alsu_select, op);
    endtask

    task automatic simple(input logic [4:0] op, input logic [1:0] rs1, input logic [1:0] rs2,
                          input logic [1:0] rd, input logic wb, input int stall);
        run_cmd(op, rs1, rs2, rd, wb, 1'b0, 2'd0, 4'd0, 1'b0, 2'd0, 4'd0, stall);
    endtask

    task automatic read_all();
        for (int i = 0; i < 4; i++) begin
            simple(SEL_PASS, 2'(i), 2'(i), 2'd0, 1'b0, 0);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        for (int i = 0; i < 4; i++) m_rf[i] = 4'h0;
        rst_n         = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = '0;
        bus.cmd_rs1   = '0;
        bus.cmd_rs2   = '0;
        bus.cmd_rd    = '0;
        bus.cmd_wb    = 1'b0;
        bus.ld_en     = 1'b0;
        bus.ld_addr   = '0;
        bus.ld_data   = '0;
        bus.rsp_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_cmd_ready", bus.cmd_ready, 1);
        chk("rst_rsp_data", bus.rsp_data, 0);
        chk("rst_rsp_zero", bus.rsp_zero, 1);
        chk("rst_rsp_carry", bus.rsp_carry, 0);
        chk("rst_select", bus.alsu_select, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // add with carry and writeback
        ld(2'd0, 4'h9);
        ld(2'd1, 4'h8);
        simple(SEL_ADD, 2'd0, 2'd1, 2'd2, 1'b1, 0);
        read_all();

        // response backpressure
        simple(SEL_ADD, 2'd0, 2'd1, 2'd3, 1'b0, 5);

        // writeback beats a load to the same entry
        ld(2'd0, 4'h1);
        ld(2'd1, 4'h2);
        run_cmd(SEL_ADD, 2'd0, 2'd1, 2'd2, 1'b1, 1'b0, 2'd0, 4'h0, 1'b1, 2'd2, 4'hF, 0);
        read_all();

        // load on the accept edge is not seen by the operand read
        ld(2'd0, 4'h2);
        run_cmd(SEL_ADD, 2'd0, 2'd1, 2'd3, 1'b0, 1'b1, 2'd0, 4'h5, 1'b0, 2'd0, 4'h0, 0);
        read_all();

        // zero result, no writeback
        ld(2'd0, 4'h7);
        ld(2'd1, 4'h7);
        simple(SEL_SUB, 2'd0, 2'd1, 2'd2, 1'b0, 1);
        read_all();

        // reset while in ISSUE
        ld(2'd3, 4'hC);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = SEL_ADD;
        bus.cmd_rs1   = 2'd0;
        bus.cmd_rs2   = 2'd3;
        bus.cmd_rd    = 2'd1;
        bus.cmd_wb    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("midrst_rsp_valid", bus.rsp_valid, 0);
        chk("midrst_cmd_ready", bus.cmd_ready, 1);
        chk("midrst_a", bus.alsu_a, 0);
        chk("midrst_rsp_data", bus.rsp_data, 0);
        for (int i = 0; i < 4; i++) m_rf[i] = 4'h0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        read_all();

        // random commands with random loads and backpressure
        for (int n = 0; n < 60; n++) begin
            logic [4:0] op;
            case ($urandom_range(0, 3))
                0:       op = SEL_PASS;
                1:       op = SEL_ADD;
                2:       op = SEL_SUB;
                default: op = 5'($urandom());
            endcase
            if ($urandom_range(0, 2) == 0) ld(2'($urandom()), 4'($urandom()));
            run_cmd(op, 2'($urandom()), 2'($urandom()), 2'($urandom()), 1'($urandom()),
                    1'($urandom()), 2'($urandom()), 4'($urandom()),
                    1'($urandom()), 2'($urandom()), 4'($urandom()),
                    $urandom_range(0, 3));
        end
        read_all();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
